// File: rtl/debug_scan_master.sv
// rtl/debug_scan_master.sv - debug-port scan initiator: sweeps core debug addresses and streams {addr,data}
// Optional feature macro: DEBUG_SCAN_AUTORUN_EN (adds i_auto_run for continuous step+scan sessions).
module debug_scan_master #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 128,
    parameter int SETTLE_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_step_req,
`ifdef DEBUG_SCAN_AUTORUN_EN
    input  logic              i_auto_run,
`endif
    output logic              o_debug_en,
    output logic              o_debug_step,
    output logic [ADDR_W-1:0] o_debug_addr,
    input  logic [DATA_W-1:0] i_debug_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STEP   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int              CNT_W     = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        r_state;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              w_auto_run;

`ifdef DEBUG_SCAN_AUTORUN_EN
    assign w_auto_run = i_auto_run;
`else
    assign w_auto_run = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_en    <= 1'b1;
                        r_addr  <= '0;
                        r_cnt   <= '0;
                        r_state <= i_step_req ? S_STEP : S_SETTLE;
                    end
                end
                S_STEP: r_state <= S_SETTLE;
                S_SETTLE: begin
                    // debug_data is combinational from debug_addr; sample only after it settles
                    if (r_cnt == LAST_CNT) begin
                        r_cnt      <= '0;
                        r_out_data <= i_debug_data;
                        r_out_addr <= r_addr;
                        r_state    <= S_EMIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (i_out_ready) begin
                        if (r_addr == LAST_ADDR) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    r_addr <= '0;
                    if (w_auto_run) begin
                        r_state <= S_STEP;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_debug_en   = r_en;
    assign o_debug_step = (r_state == S_STEP);
    assign o_debug_addr = r_addr;
    assign o_out_valid  = (r_state == S_EMIT);
    assign o_out_addr   = r_out_addr;
    assign o_out_data   = r_out_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_debug_scan_master.sv
// tb/tb_debug_scan_master.sv - scoreboard bench for debug_scan_master (NUM_REGS=4, SETTLE_CYC=2)
module tb_debug_scan_master;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 4;
    localparam int SETTLE_CYC = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              step_req = 1'b0;
    logic              auto_run = 1'b0;
    logic              out_ready = 1'b1;
    logic              debug_en, debug_step, out_valid, busy, done;
    logic [ADDR_W-1:0] debug_addr, out_addr;
    logic [DATA_W-1:0] debug_data, out_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int step_cnt, done_cnt, word_cnt, first_step, first_valid, done_cyc;
    bit en_bad;
    bit stall_bad;
    logic [ADDR_W+DATA_W-1:0] sb_q[$];

    debug_scan_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_req(step_req),
`ifdef DEBUG_SCAN_AUTORUN_EN
        .i_auto_run(auto_run),
`endif
        .o_debug_en(debug_en), .o_debug_step(debug_step), .o_debug_addr(debug_addr),
        .i_debug_data(debug_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_addr(out_addr), .o_out_data(out_data), .o_busy(busy), .o_done(done)
    );

    // core model: each register reads back as its address times four
    assign debug_data = DATA_W'(debug_addr) << 2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (debug_step) begin
                step_cnt++;
                if (first_step == 0) first_step = cyc - t0 + 1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0 + 1;
            end
            if (busy && !debug_en) en_bad = 1'b1;
            if (out_valid && first_valid == 0) first_valid = cyc - t0 + 1;
            if (out_valid && out_ready) begin
                word_cnt++;
                if (sb_q.size() == 0) check_val("extra_word", 64'({out_addr, out_data}), 64'hdead);
                else check_val("word", 64'({out_addr, out_data}), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic push_scans(input int n);
        for (int s = 0; s < n; s++)
            for (int a = 0; a < NUM_REGS; a++)
                sb_q.push_back({ADDR_W'(a), DATA_W'(a * 4)});
    endtask

    task automatic start_session(input logic sreq, input int scans);
        @(posedge clk); #1;
        step_cnt = 0; done_cnt = 0; word_cnt = 0;
        first_step = 0; first_valid = 0; done_cyc = 0; en_bad = 1'b0;
        t0 = cyc;
        push_scans(scans);
        start = 1'b1; step_req = sreq;
        @(posedge clk); #1;
        start = 1'b0; step_req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) break;
        end
        if (n >= 400) check_val("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    initial begin
        #1;
        check_val("rst_outs", 64'({debug_en, debug_step, debug_addr, out_valid, out_addr, out_data, busy, done}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 64'(busy), 64'd0);

        // plain scan, no step
        start_session(1'b0, 1);
        wait_done(1);
        repeat (3) @(posedge clk);
        check_val("t2_done_cyc", 64'(done_cyc), 64'd14);
        check_val("t2_first_valid", 64'(first_valid), 64'd4);
        check_val("t2_steps", 64'(step_cnt), 64'd0);
        check_val("t2_words", 64'(word_cnt), 64'(NUM_REGS));
        check_val("t2_en_after", 64'(debug_en), 64'd0);

        // scan preceded by a single step
        start_session(1'b1, 1);
        wait_done(1);
        repeat (3) @(posedge clk);
        check_val("t3_steps", 64'(step_cnt), 64'd1);
        check_val("t3_step_cyc", 64'(first_step), 64'd2);
        check_val("t3_first_valid", 64'(first_valid), 64'd5);
        check_val("t3_done_cyc", 64'(done_cyc), 64'd15);

        // backpressure at address 2
        start_session(1'b0, 1);
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                @(negedge clk); #1;
                if (debug_addr == 2) break;
            end
            if (n >= 100) check_val("t4_addr_timeout", 64'(debug_addr), 64'd2);
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        stall_bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!(out_valid && out_addr == 2 && debug_addr == 2 && out_data == 8)) stall_bad = 1'b1;
        end
        check_val("t4_stall_hold", 64'(stall_bad), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(1);
        repeat (3) @(posedge clk);
        check_val("t4_words", 64'(word_cnt), 64'(NUM_REGS));
        check_val("t4_sb_empty", 64'(sb_q.size()), 64'd0);

        // start while busy must be ignored
        start_session(1'b0, 1);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1);
        repeat (20) @(posedge clk);
        check_val("t5_dones", 64'(done_cnt), 64'd1);
        check_val("t5_words", 64'(word_cnt), 64'(NUM_REGS));
        check_val("t5_busy", 64'(busy), 64'd0);

        // asynchronous reset in the middle of a scan
        start_session(1'b1, 1);
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                @(negedge clk);
                if (out_valid && out_addr == 1) break;
            end
            if (n >= 100) check_val("t1_valid_timeout", 64'(out_valid), 64'd1);
        end
        #1 rst = 1'b1;
        #1 check_val("t1_outs_zero", 64'({debug_en, debug_step, debug_addr, out_valid, out_addr, out_data, busy, done}), 64'd0);
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_val("t1_busy", 64'(busy), 64'd0);
        check_val("t1_en", 64'(debug_en), 64'd0);
        repeat (30) @(posedge clk);
        check_val("t1_no_done", 64'(done_cnt), 64'd0);

`ifdef DEBUG_SCAN_AUTORUN_EN
        auto_run = 1'b1;
        start_session(1'b1, 3);
        wait_done(2);
        @(posedge clk); #1 auto_run = 1'b0;
        wait_done(3);
        repeat (10) @(posedge clk);
        check_val("t6_dones", 64'(done_cnt), 64'd3);
        check_val("t6_steps", 64'(step_cnt), 64'd3);
        check_val("t6_en_drop", 64'(en_bad), 64'd0);
        check_val("t6_words", 64'(word_cnt), 64'(3 * NUM_REGS));
        check_val("t6_idle", 64'({busy, debug_en}), 64'd0);
`endif

        check_val("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
